// File: rtl/delay_line_pkg.sv
// ---------------------------------------------------------------------------
// delay_line_pkg
// Shared types, default parameter values and width helpers for the
// variable delay line (var_delay_line) and its sample memory (delay_ram).
// Contents:
//   vdl_state_t  : FILL (history not yet deep enough) / RUN (output trusted)
//   DEFAULT_*    : default parameter values
//   delay_width  : bits needed to hold a delay of 0..max_delay
//   ptr_width    : bits needed to address a max_delay-deep memory (min 1)
// ---------------------------------------------------------------------------
package delay_line_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } vdl_state_t;

  localparam int DEFAULT_DATA_WIDTH  = 12;
  localparam int DEFAULT_CHANNELS    = 2;
  localparam int DEFAULT_MAX_DELAY   = 16;
  localparam int DEFAULT_RESET_DELAY = 8;

  function automatic int delay_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // A one-entry memory still needs a 1-bit pointer to stay legal.
  function automatic int ptr_width(input int max_delay);
    return (max_delay <= 1) ? 1 : $clog2(max_delay);
  endfunction

endpackage

// File: rtl/var_delay_line_ram.sv
// ---------------------------------------------------------------------------
// delay_ram
// Sample history memory for var_delay_line: one WIDTH-bit word per accepted
// sample (all channels packed together), DEPTH words deep. Synchronous
// write, combinational read, so a read of the address being written this
// cycle returns the previous contents. The array is deliberately not reset.
// Ports:
//   clk      in   rising-edge clock
//   we       in   write enable
//   wr_addr  in   [AW]    write address
//   wr_data  in   [WIDTH] write data
//   rd_addr  in   [AW]    read address
//   rd_data  out  [WIDTH] read data (combinational)
// ---------------------------------------------------------------------------
module delay_ram
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/var_delay_line.sv
// ---------------------------------------------------------------------------
// var_delay_line
// Multi-channel, sample-qualified delay line with a runtime-programmable
// delay of 0..MAX_DELAY accepted samples. It advances only when in_valid is
// high, so gaps in the sample stream do not disturb lane alignment.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   data_in carries a sample this cycle
//   data_in     in   [CHANNELS*DATA_WIDTH] channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   delay_load  in   one-cycle strobe: load delay_sel
//   delay_sel   in   [DW] requested delay, DW = $clog2(MAX_DELAY+1)
//   data_out    out  [CHANNELS*DATA_WIDTH] delayed samples, same packing
//   out_valid   out  data_out was updated with a valid delayed sample
//   primed      out  enough history is held for the active delay
//   delay_err   out  one-cycle pulse: delay_load rejected (delay_sel > MAX_DELAY)
// Build option:
//   VAR_DELAY_FLUSH_ON_LOAD_EN - an accepted delay load discards the history
//   count, so output resumes only after new-delay fresh samples.
// ---------------------------------------------------------------------------
module var_delay_line
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int MAX_DELAY   = DEFAULT_MAX_DELAY,
  parameter int RESET_DELAY = DEFAULT_RESET_DELAY,
  parameter int DW          = delay_width(MAX_DELAY)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           delay_load,
  input  logic [DW-1:0]                  delay_sel,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           out_valid,
  output logic                           primed,
  output logic                           delay_err
);

  localparam int              PW       = ptr_width(MAX_DELAY);
  localparam int              LW       = CHANNELS * DATA_WIDTH;
  localparam logic [DW-1:0]   MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW-1:0]   RST_D    = DW'(RESET_DELAY);
  localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_DELAY - 1);
  localparam logic [DW:0]     DEPTH_X  = (DW+1)'(MAX_DELAY);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] fill_cnt;
  logic [DW-1:0] fill_next;
  logic [DW-1:0] active_delay;
  logic [DW-1:0] delay_next;
  logic [DW:0]   ptr_ext;
  logic [DW:0]   dly_ext;
  logic [DW:0]   rd_sum;
  logic [LW-1:0] rd_data;
  logic          load_ok;
  logic          load_bad;
  logic          have_history;
  vdl_state_t    state;
  vdl_state_t    state_next;

  assign load_ok      = delay_load && (delay_sel <= MAX_D);
  assign load_bad     = delay_load && (delay_sel > MAX_D);
  assign have_history = (fill_cnt >= active_delay);

  // Read address is wr_ptr - active_delay modulo the memory depth, taken
  // before this cycle's write. One extra bit keeps the add/subtract exact.
  always_comb begin
    ptr_ext = (DW+1)'(wr_ptr);
    dly_ext = {1'b0, active_delay};
    if (dly_ext > ptr_ext) begin
      rd_sum = ptr_ext + DEPTH_X - dly_ext;
    end else begin
      rd_sum = ptr_ext - dly_ext;
    end
    rd_addr = rd_sum[PW-1:0];
  end

  // History count and delay for the next cycle. A delay load that arrives
  // with a sample still uses the old delay for that sample's output.
  always_comb begin
    fill_next  = fill_cnt;
    delay_next = active_delay;
    if (in_valid && (fill_cnt != MAX_D)) begin
      fill_next = fill_cnt + 1'b1;
    end
`ifdef VAR_DELAY_FLUSH_ON_LOAD_EN
    if (load_ok) begin
      fill_next = '0;
    end
`endif
    if (load_ok) begin
      delay_next = delay_sel;
    end
  end

  // FILL until the history covers the active delay; a delay change that
  // outruns the history drops back to FILL.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    state_next = (fill_next >= delay_next) ? RUN : FILL;
      RUN:     state_next = (fill_next < delay_next) ? FILL : RUN;
      default: state_next = FILL;
    endcase
  end

  // Pointer, control state and output registers. A zero delay bypasses the
  // memory because the read would otherwise see the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      active_delay <= RST_D;
      state        <= FILL;
      data_out     <= '0;
      out_valid    <= 1'b0;
      delay_err    <= 1'b0;
    end else begin
      if (in_valid) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      fill_cnt     <= fill_next;
      active_delay <= delay_next;
      state        <= state_next;
      delay_err    <= load_bad;
      if (in_valid && have_history) begin
        data_out  <= (active_delay == '0) ? data_in : rd_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign primed = (state == RUN);

  delay_ram #(
    .WIDTH (LW),
    .DEPTH (MAX_DELAY),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we      (in_valid),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_var_delay_line.sv
// ---------------------------------------------------------------------------
// tb_var_delay_line
// Directed, table-driven bench for var_delay_line with default parameters.
// Sample k is packed as ch0 = k, ch1 = -(k+1); an expected sample of -1
// means an all-zero data_out (reset value, nothing emitted yet).
// Honours VAR_DELAY_FLUSH_ON_LOAD_EN for the delay-change expectations.
// ---------------------------------------------------------------------------
module tb_var_delay_line;
  import delay_line_pkg::*;

  localparam int DATA_WIDTH  = 12;
  localparam int CHANNELS    = 2;
  localparam int MAX_DELAY   = 16;
  localparam int RESET_DELAY = 8;
  localparam int DW          = $clog2(MAX_DELAY + 1);
  localparam int LW          = CHANNELS * DATA_WIDTH;
`ifdef VAR_DELAY_FLUSH_ON_LOAD_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    bit rst;
    bit vld;
    int smp;
    bit ld;
    int sel;
    bit exp_ov;
    int exp_smp;
    bit exp_primed;
    bit exp_err;
  } vec_t;

  vec_t vecs[$];
  int compared   = 0;
  int mismatched = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [LW-1:0] data_in;
  logic          delay_load;
  logic [DW-1:0] delay_sel;
  logic [LW-1:0] data_out;
  logic          out_valid;
  logic          primed;
  logic          delay_err;

  var_delay_line #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHANNELS    (CHANNELS),
    .MAX_DELAY   (MAX_DELAY),
    .RESET_DELAY (RESET_DELAY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .delay_load (delay_load),
    .delay_sel  (delay_sel),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .primed     (primed),
    .delay_err  (delay_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] packSample(input int k);
    logic [DATA_WIDTH-1:0] c0;
    logic [DATA_WIDTH-1:0] c1;
    if (k < 0) return '0;
    c0 = DATA_WIDTH'(k);
    c1 = DATA_WIDTH'(-(k + 1));
    return {c1, c0};
  endfunction

  function automatic void addRow(input bit rst, input bit vld, input int smp,
                                 input bit ld, input int sel, input bit exp_ov,
                                 input int exp_smp, input bit exp_primed,
                                 input bit exp_err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.smp = smp; v.ld = ld; v.sel = sel;
    v.exp_ov = exp_ov; v.exp_smp = exp_smp;
    v.exp_primed = exp_primed; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic checkBit(input string name, input int idx, input logic act,
                          input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %0b, want %0b", name, idx, act, exp);
    end
  endtask

  // Four comparisons per step: out_valid, data_out, primed, delay_err.
  task automatic checkOutput(input int idx, input bit exp_ov, input int exp_smp,
                             input bit exp_primed, input bit exp_err);
    logic [LW-1:0] exp_data;
    exp_data = packSample(exp_smp);
    checkBit("out_valid", idx, out_valid, exp_ov);
    compared++;
    if (data_out !== exp_data) begin
      mismatched++;
      $display("[TB] FAIL data_out step %0d: got %h, want %h", idx, data_out, exp_data);
    end
    checkBit("primed", idx, primed, exp_primed);
    checkBit("delay_err", idx, delay_err, exp_err);
  endtask

  // Entered at posedge+1; optionally pulses reset, drives one cycle of
  // inputs and returns at the next posedge+1 with strobes cleared.
  task automatic applyStimulus(input vec_t v);
    if (v.rst) begin
      in_valid   = 1'b0;
      delay_load = 1'b0;
      rst_n      = 1'b0;
      #2;
      rst_n      = 1'b1;
    end
    in_valid   = v.vld;
    data_in    = v.vld ? packSample(v.smp) : '0;
    delay_load = v.ld;
    delay_sel  = DW'(v.sel);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    delay_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    delay_load = 1'b0;
    delay_sel  = '0;

    // Reset delay 8, 50% duty ramp: first valid after the 9th sample.
    for (int k = 0; k < 20; k++) begin
      addRow(k == 0, 1, k, 0, 0, k >= 8, (k >= 8) ? k - 8 : -1, k >= 7, 0);
      addRow(0, 0, 0, 0, 0, 0, (k >= 8) ? k - 8 : -1, k >= 7, 0);
    end
    // Delay 0: one-cycle registered pass-through.
    addRow(1, 0, 0, 1, 0, 0, -1, 1, 0);
    for (int k = 0; k < 10; k++) addRow(0, 1, k, 0, 0, 1, k, 1, 0);
    // Delay 16 (full depth) over two pointer wraps.
    addRow(1, 0, 0, 1, 16, 0, -1, 0, 0);
    for (int k = 0; k < 40; k++)
      addRow(0, 1, k, 0, 0, k >= 16, (k >= 16) ? k - 16 : -1, k >= 15, 0);
    // Running at 8, switch to 3 together with sample 12.
    for (int k = 0; k < 12; k++)
      addRow(k == 0, 1, k, 0, 0, k >= 8, (k >= 8) ? k - 8 : -1, k >= 7, 0);
    addRow(0, 1, 12, 1, 3, 1, 4, !FLUSH, 0);
    for (int k = 13; k < 19; k++) begin
      if (FLUSH) addRow(0, 1, k, 0, 0, k >= 16, (k >= 16) ? k - 3 : 4, k >= 15, 0);
      else       addRow(0, 1, k, 0, 0, 1, k - 3, 1, 0);
    end
    // Out-of-range delay loads are rejected and leave the stream alone.
    addRow(0, 1, 19, 1, 17, 1, 16, 1, 1);
    addRow(0, 1, 20, 0, 0, 1, 17, 1, 0);
    addRow(0, 0, 0, 1, 31, 0, 17, 1, 1);
    addRow(0, 1, 21, 0, 0, 1, 18, 1, 0);

    #12;
    checkOutput(-1, 0, -1, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].exp_ov, vecs[i].exp_smp, vecs[i].exp_primed, vecs[i].exp_err);
    end

    // Asynchronous reset between edges while primed and streaming.
    for (int k = 0; k < 12; k++) begin
      v = '{rst: (k == 0), vld: 1, smp: k, ld: 0, sel: 0,
            exp_ov: 0, exp_smp: 0, exp_primed: 0, exp_err: 0};
      applyStimulus(v);
      checkOutput(1000 + k, k >= 8, (k >= 8) ? k - 8 : -1, k >= 7, 0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput(2000, 0, -1, 0, 0);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 9; j++) begin
      v = '{rst: 0, vld: 1, smp: 100 + j, ld: 0, sel: 0,
            exp_ov: 0, exp_smp: 0, exp_primed: 0, exp_err: 0};
      applyStimulus(v);
      checkOutput(3000 + j, j == 8, (j == 8) ? 100 : -1, j >= 7, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
